deal_sequencer: RTL and testbench
=================================

DEAL_SEQUENCER -- requirements
Module: deal_sequencer

Interface
REQ-001 Parameter: IDLE_CYCLES, default 1, cycles spent in IDLE before the first card load; legal range 1..15.
REQ-002 slow_clock  input  1  sole clock; all state changes on its rising edge.
REQ-003 resetb  input  1  synchronous, active-high reset, sampled on the rising edge of slow_clock.
REQ-004 pscore_in  input  4  player hand score from the datapath, 0..9, combinational from the loaded cards.
REQ-005 dscore_in  input  4  banker hand score from the datapath, 0..9.
REQ-006 pcard3_in  input  4  player third card rank, 1..13; 0 = empty.
REQ-007 load_pcard1, load_pcard2, load_pcard3  output  1 each  load enables for the player card registers.
REQ-008 load_dcard1, load_dcard2, load_dcard3  output  1 each  load enables for the banker card registers.
REQ-009 player_win_light, dealer_win_light  output  1 each  round result; both high = tie.
REQ-010 done  output  1  round complete.

Function
REQ-011 States SHALL be IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL_P, DEAL_P3, EVAL_B, DEAL_D3, DONE.
REQ-012 All outputs SHALL be Moore-decoded from the state register, with no input-to-output combinational path except the win lights in DONE.
REQ-013 At most one load output SHALL be high in any cycle: load_pcard1 in DEAL_P1, load_dcard1 in DEAL_D1, load_pcard2 in DEAL_P2, load_dcard2 in DEAL_D2, load_pcard3 in DEAL_P3, load_dcard3 in DEAL_D3.
REQ-014 The datapath captures each card on the edge that leaves the load state; scores SHALL be sampled only in the state after that load.
REQ-015 IDLE SHALL count IDLE_CYCLES cycles with a 4-bit counter, then go to DEAL_P1; the counter clears on entry to IDLE.
REQ-016 The sequence DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2 -> EVAL_P SHALL be unconditional, one cycle per state.
REQ-017 EVAL_P: if pscore_in >= 8 or dscore_in >= 8 (natural), go to DONE.
REQ-018 EVAL_P, no natural, pscore_in <= 5: go to DEAL_P3.
REQ-019 EVAL_P, no natural, pscore_in 6..7: go to DEAL_D3 if dscore_in <= 5; otherwise go to DONE.
REQ-020 DEAL_P3 SHALL always go to EVAL_B.
REQ-021 EVAL_B SHALL compute the third-card value v = 0 if pcard3_in >= 10, else pcard3_in.
REQ-022 EVAL_B banker draw rule, on dscore_in: 0..2 draw; 3 draw unless v = 8; 4 draw if v in 2..7; 5 draw if v in 4..7; 6 draw if v in 6..7; 7..9 stand.
REQ-023 EVAL_B SHALL go to DEAL_D3 on draw and to DONE on stand.
REQ-024 DEAL_D3 SHALL always go to DONE.
REQ-025 DONE SHALL hold until reset, with done = 1 and all loads 0.
REQ-026 In DONE only: player_win_light = (pscore_in > dscore_in); dealer_win_light = (dscore_in > pscore_in); both = 1 when equal.
REQ-027 Outside DONE, both win lights and done SHALL be 0.
REQ-028 Score inputs outside 0..9 in an EVAL state SHALL be treated as 9 (stand/natural); the state machine SHALL never enter an undefined state.
REQ-029 Unused state encodings SHALL return to IDLE on the next edge.

Reset
REQ-030 resetb = 1 on an edge SHALL force IDLE and clear the counter, with priority over every transition including mid-deal.
REQ-031 While in IDLE after reset, all load outputs, done and both win lights SHALL be 0.
REQ-032 A full round with IDLE_CYCLES = 1 SHALL take 7 cycles (natural) to 10 cycles (both third cards) from reset release to done = 1.

Verification
REQ-033 Reset released, pscore_in = 8, dscore_in = 3 at EVAL_P -> loads pulse P1, D1, P2, D2 once each, no third-card loads, DONE with player_win_light = 1, dealer_win_light = 0.
REQ-034 pscore_in = 6, dscore_in = 5 at EVAL_P -> load_dcard3 pulses once, load_pcard3 never; final scores 6/9 -> dealer_win_light = 1 only.
REQ-035 pscore_in = 3, dscore_in = 6 at EVAL_P:
  - pcard3_in = 7 at EVAL_B -> load_dcard3 pulses.
  - Repeated with pcard3_in = 12 (v = 0) -> no load_dcard3; DONE follows EVAL_B.
REQ-036 dscore_in = 3 and pcard3_in = 8 at EVAL_B -> banker stands; same scores with pcard3_in = 9 -> banker draws.
REQ-037 Final pscore_in = dscore_in = 7 in DONE -> both win lights = 1 and done = 1.
REQ-038 resetb asserted for one cycle while in DEAL_P2 -> next cycle IDLE with all outputs 0; a full new deal then starts from DEAL_P1 after IDLE_CYCLES.

Source files
------------

// File: rtl/deal_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deal_sequencer_if : card-load enables and score feedback between the |
// | baccarat deal sequencer (master) and its card datapath (slave).      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface deal_sequencer_if;
  logic [3:0] pscore_in;
  logic [3:0] dscore_in;
  logic [3:0] pcard3_in;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       done;

  modport master (
    input  pscore_in, dscore_in, pcard3_in,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, done
  );

  modport slave (
    output pscore_in, dscore_in, pcard3_in,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, done
  );
endinterface
`default_nettype wire

// File: rtl/deal_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deal_sequencer : Moore FSM sequencing one baccarat round.            |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module deal_sequencer #(
  parameter int unsigned IDLE_CYCLES = 1
) (
  input  wire logic        slow_clock,
  input  wire logic        resetb,
  deal_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEAL_P1 = 4'd1,
    S_DEAL_D1 = 4'd2,
    S_DEAL_P2 = 4'd3,
    S_DEAL_D2 = 4'd4,
    S_EVAL_P  = 4'd5,
    S_DEAL_P3 = 4'd6,
    S_EVAL_B  = 4'd7,
    S_DEAL_D3 = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [3:0] C_IDLE_LAST = 4'(IDLE_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] pscore_c, dscore_c, third_v;
  logic       natural, banker_draw;

  // Out-of-range scores saturate to 9 so a corrupt datapath value stands.
  always_comb begin
    pscore_c    = (bus.pscore_in > 4'd9) ? 4'd9 : bus.pscore_in;
    dscore_c    = (bus.dscore_in > 4'd9) ? 4'd9 : bus.dscore_in;
    third_v     = (bus.pcard3_in >= 4'd10) ? 4'd0 : bus.pcard3_in;
    natural     = (pscore_c >= 4'd8) || (dscore_c >= 4'd8);
    banker_draw = 1'b0;
    case (dscore_c)
      4'd0, 4'd1, 4'd2: banker_draw = 1'b1;
      4'd3:             banker_draw = (third_v != 4'd8);
      4'd4:             banker_draw = (third_v >= 4'd2) && (third_v <= 4'd7);
      4'd5:             banker_draw = (third_v >= 4'd4) && (third_v <= 4'd7);
      4'd6:             banker_draw = (third_v >= 4'd6) && (third_v <= 4'd7);
      default:          banker_draw = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cnt_q >= C_IDLE_LAST) begin
          state_d = S_DEAL_P1;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DEAL_P1: state_d = S_DEAL_D1;
      S_DEAL_D1: state_d = S_DEAL_P2;
      S_DEAL_P2: state_d = S_DEAL_D2;
      S_DEAL_D2: state_d = S_EVAL_P;
      S_EVAL_P: begin
        if (natural)                state_d = S_DONE;
        else if (pscore_c <= 4'd5)  state_d = S_DEAL_P3;
        else if (dscore_c <= 4'd5)  state_d = S_DEAL_D3;
        else                        state_d = S_DONE;
      end
      S_DEAL_P3: state_d = S_EVAL_B;
      S_EVAL_B:  state_d = banker_draw ? S_DEAL_D3 : S_DONE;
      S_DEAL_D3: state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Win lights are the only outputs that look at inputs, and only in DONE.
  always_comb begin
    bus.load_pcard1      = (state_q == S_DEAL_P1);
    bus.load_dcard1      = (state_q == S_DEAL_D1);
    bus.load_pcard2      = (state_q == S_DEAL_P2);
    bus.load_dcard2      = (state_q == S_DEAL_D2);
    bus.load_pcard3      = (state_q == S_DEAL_P3);
    bus.load_dcard3      = (state_q == S_DEAL_D3);
    bus.done             = (state_q == S_DONE);
    bus.player_win_light = 1'b0;
    bus.dealer_win_light = 1'b0;
    if (state_q == S_DONE) begin
      bus.player_win_light = (bus.pscore_in >= bus.dscore_in);
      bus.dealer_win_light = (bus.dscore_in >= bus.pscore_in);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_deal_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_deal_sequencer : round table with scoreboard plus reset sequences.|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_deal_sequencer;

  logic clk = 1'b0;
  logic resetb;
  always #5 clk = ~clk;

  deal_sequencer_if bus ();

  deal_sequencer #(.IDLE_CYCLES(1)) dut (
    .slow_clock (clk),
    .resetb     (resetb),
    .bus        (bus)
  );

  // p0/d0: two-card scores; db/p3/pc3 take effect when P3 is captured;
  // d3 takes effect when D3 is captured. mask bits: P1 D1 P2 D2 P3 D3 (lsb first).
  typedef struct {
    logic [3:0] p0, d0, db, pc3, p3, d3;
    logic [5:0] mask;
    int         cyc;
    logic       pw, dw;
  } vec_t;

  typedef struct {
    logic [5:0] mask;
    int         cyc;
    logic       pw, dw;
  } exp_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int p0, int d0, int db, int pc3, int p3, int d3,
                              logic [5:0] mask, int cyc, logic pw, logic dw);
    vec_t v;
    v.p0 = 4'(p0); v.d0 = 4'(d0); v.db = 4'(db); v.pc3 = 4'(pc3);
    v.p3 = 4'(p3); v.d3 = 4'(d3); v.mask = mask; v.cyc = cyc;
    v.pw = pw; v.dw = dw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] loads();
    return {bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
            bus.load_pcard2, bus.load_dcard1, bus.load_pcard1};
  endfunction

  function automatic logic [8:0] all_outs();
    return {loads(), bus.player_win_light, bus.dealer_win_light, bus.done};
  endfunction

  task automatic set_inputs(input vec_t v);
    bus.pscore_in = v.p0;
    bus.dscore_in = v.d0;
    bus.pcard3_in = 4'd0;
  endtask

  task automatic do_reset(input string tag);
    resetb = 1'b1;
    @(posedge clk);
    #1 resetb = 1'b0;
    check({tag, "_reset_outs"}, 32'(all_outs()), 32'd0);
  endtask

  // Called just after the reset edge; cycle count is edges since that edge.
  task automatic follow_round(input vec_t v, input string tag);
    exp_t       e, got;
    logic [5:0] seen, l;
    int         cyc, pulses;
    bit         got_done;
    e.mask = v.mask; e.cyc = v.cyc; e.pw = v.pw; e.dw = v.dw;
    sb.push_back(e);
    seen = '0; cyc = 0; pulses = 0; got_done = 1'b0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      l = loads();
      check({tag, "_onehot"}, 32'($countones(l) <= 1), 32'd1);
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        check({tag, "_lights_off"},
              32'({bus.player_win_light, bus.dealer_win_light}), 32'd0);
        seen   |= l;
        pulses += $countones(l);
        @(posedge clk);
        cyc++;
        #1;
        if (l[4]) begin
          bus.pscore_in = v.p3;
          bus.dscore_in = v.db;
          bus.pcard3_in = v.pc3;
        end
        if (l[5]) bus.dscore_in = v.d3;
      end
    end
    check({tag, "_done_reached"}, 32'(got_done), 32'd1);
    got = sb.pop_front();
    check({tag, "_load_mask"}, 32'(seen), 32'(got.mask));
    check({tag, "_pulse_count"}, 32'(pulses), 32'($countones(got.mask)));
    check({tag, "_cycles"}, 32'(cyc), 32'(got.cyc));
    check({tag, "_player_light"}, 32'(bus.player_win_light), 32'(got.pw));
    check({tag, "_dealer_light"}, 32'(bus.dealer_win_light), 32'(got.dw));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_hold"}, 32'({loads(), bus.done}), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           p0 d0 db pc3 p3 d3 mask   cyc pw dw
    vecs[0]  = mk( 8, 3, 3,  0, 0, 0, 6'h0F,  7, 1, 0);
    vecs[1]  = mk( 6, 5, 5,  0, 0, 9, 6'h2F,  8, 0, 1);
    vecs[2]  = mk( 3, 6, 6,  7, 0, 2, 6'h3F, 10, 0, 1);
    vecs[3]  = mk( 3, 6, 6, 12, 3, 0, 6'h1F,  9, 0, 1);
    vecs[4]  = mk( 2, 3, 3,  8, 0, 0, 6'h1F,  9, 0, 1);
    vecs[5]  = mk( 1, 3, 3,  9, 0, 7, 6'h3F, 10, 0, 1);
    vecs[6]  = mk( 7, 7, 7,  0, 0, 0, 6'h0F,  7, 1, 1);
    vecs[7]  = mk( 7, 6, 6,  0, 0, 0, 6'h0F,  7, 1, 0);
    vecs[8]  = mk(12, 2, 2,  0, 0, 0, 6'h0F,  7, 1, 0);
    vecs[9]  = mk( 5, 4, 4,  1, 6, 0, 6'h1F,  9, 1, 0);
    vecs[10] = mk( 5, 4, 4,  2, 7, 9, 6'h3F, 10, 0, 1);
    vecs[11] = mk( 0, 5, 5,  3, 3, 0, 6'h1F,  9, 0, 1);
    vecs[12] = mk( 0, 5, 5,  4, 4, 1, 6'h3F, 10, 1, 0);
    vecs[13] = mk( 4, 6, 6,  5, 9, 0, 6'h1F,  9, 1, 0);
    vecs[14] = mk( 0, 0, 0, 13, 0, 5, 6'h3F, 10, 0, 1);
    vecs[15] = mk( 2, 3,14,  1, 3, 0, 6'h1F,  9, 0, 1);
    vecs[16] = mk( 6, 7, 7,  0, 0, 0, 6'h0F,  7, 0, 1);
    vecs[17] = mk( 4,11,11,  0, 0, 0, 6'h0F,  7, 0, 1);
    vecs[18] = mk( 3, 7, 7,  6, 9, 0, 6'h1F,  9, 1, 0);

    resetb = 1'b1;
    set_inputs(vecs[0]);
    repeat (3) begin
      @(posedge clk);
      #1 check("held_reset_outs", 32'(all_outs()), 32'd0);
    end

    for (int i = 0; i < NV; i++) begin
      set_inputs(vecs[i]);
      do_reset($sformatf("vec%0d", i));
      follow_round(vecs[i], $sformatf("vec%0d", i));
    end

    // Abort mid-deal in DEAL_P2, then a clean round must follow.
    begin
      bit hit;
      hit = 1'b0;
      set_inputs(vecs[0]);
      do_reset("abort");
      for (int k = 0; k < 20 && !hit; k++) begin
        @(negedge clk);
        if (bus.load_pcard2) hit = 1'b1;
      end
      check("abort_reached_p2", 32'(hit), 32'd1);
      resetb = 1'b1;
      @(posedge clk);
      #1 resetb = 1'b0;
      check("abort_idle_outs", 32'(all_outs()), 32'd0);
      follow_round(vecs[0], "abort_redeal");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
